// File: rtl/n64_pkg.sv
// Shared definitions for the N64 controller responder.
// Command codes, register indices, FSM states, timing helper.
package n64_pkg;

    localparam logic [7:0] CMD_STATUS = 8'h00;
    localparam logic [7:0] CMD_POLL   = 8'h01;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam logic [1:0] REG_BUTTONS = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_POLLCNT = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RX_BIT,
        RX_STOP,
        IGNORE,
        GAP,
        TX,
        TX_STOP
    } state_t;

    function automatic int us_to_clks(input int us, input int clks_per_us);
        return us * clks_per_us;
    endfunction

endpackage

// File: rtl/n64_bit_tx.sv
// One N64 line bit: '0' = 3us low + 1us high, '1' = 1us low + 3us high.
// done is high on the last clock of the 4us bit cell.
module n64_bit_tx import n64_pkg::*; #(
    parameter int CLKS_PER_US = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_val,
    output logic line_low,
    output logic done
);

    localparam int BIT_CLKS = us_to_clks(4, CLKS_PER_US);
    localparam int CW = $clog2(BIT_CLKS + 1);
    localparam logic [CW-1:0] LAST = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] ONE_LOW = CW'(us_to_clks(1, CLKS_PER_US));
    localparam logic [CW-1:0] ZERO_LOW = CW'(us_to_clks(3, CLKS_PER_US));

    logic          active;
    logic          val;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            val    <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            val    <= bit_val;
            cnt    <= '0;
        end else if (active) begin
            if (cnt == LAST)
                active <= 1'b0;
            cnt <= cnt + 1'b1;
        end
    end

    assign line_low = active && (cnt < (val ? ONE_LOW : ZERO_LOW));
    assign done     = active && (cnt == LAST);

endmodule

// File: rtl/n64_controller_responder.sv
// N64 controller emulator: decodes host commands on Din, answers on Dout.
// Define N64_RESP_IRQ_EN to add the IRQ port and STATUS[2] irq_pend.
module n64_controller_responder import n64_pkg::*; #(
    parameter int          CLKS_PER_US = 100,
    parameter int          IDLE_TO_US  = 16,
    parameter int          RESP_GAP_US = 2,
    parameter logic [23:0] DEV_ID      = 24'h050002
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [31:0] PRDATA,
`ifdef N64_RESP_IRQ_EN
    output logic        IRQ,
`endif
    input  logic        Din,
    output logic        Dout
);

    localparam int TW = $clog2(16 * CLKS_PER_US + 1);
    localparam logic [TW-1:0] IDLE_CLKS =
        TW'(us_to_clks(IDLE_TO_US, CLKS_PER_US));
    localparam logic [TW-1:0] SAMPLE_AT = TW'(us_to_clks(2, CLKS_PER_US) - 1);
    localparam logic [TW-1:0] GAP_END =
        TW'(us_to_clks(RESP_GAP_US, CLKS_PER_US) - 1);
    localparam logic [TW-1:0] STOP_END = TW'(us_to_clks(2, CLKS_PER_US) - 1);

    state_t        state, state_nx;
    logic          din_s1, din_s2, din_q;
    logic [TW-1:0] tmr, idle_cnt;
    logic          flag;
    logic [5:0]    bit_cnt;
    logic [7:0]    rx_sr, last_cmd;
    logic [31:0]   tx_sr, buttons;
    logic          rx_err;
    logic [15:0]   poll_cnt;
    logic          st_irq;

    logic din_fall, din_rise, idle_hit, sample, is_known;
    logic tx_start, abort, cmd_done, tx_end, poll_done;
    logic bit_low, bit_done, apb_wr, ctrl_wr, busy;
    logic unused_apb;

    assign din_fall  = din_q & ~din_s2;
    assign din_rise  = ~din_q & din_s2;
    assign idle_hit  = (idle_cnt == IDLE_CLKS);
    assign sample    = (state == RX_BIT) && !flag && (tmr == SAMPLE_AT);
    assign is_known  = (rx_sr == CMD_STATUS) || (rx_sr == CMD_RESET) ||
                       (rx_sr == CMD_POLL);
    assign poll_done = tx_end && (last_cmd == CMD_POLL);
    assign apb_wr    = PSEL & PENABLE & PWRITE;
    assign ctrl_wr   = apb_wr && (PADDR[3:2] == REG_CTRL);
    assign busy      = (state != IDLE);
    assign PREADY    = 1'b1;
    assign PSLVERR   = 1'b0;
    assign unused_apb = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:1]};

    n64_bit_tx #(.CLKS_PER_US(CLKS_PER_US)) u_bit_tx (
        .clk      (PCLK),
        .rst_n    (PRESERN),
        .start    (tx_start),
        .bit_val  (tx_sr[31]),
        .line_low (bit_low),
        .done     (bit_done)
    );

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        tx_start = 1'b0;
        abort    = 1'b0;
        cmd_done = 1'b0;
        tx_end   = 1'b0;
        unique case (state)
            IDLE:
                if (din_fall)
                    state_nx = RX_BIT;
            RX_BIT:
                if (idle_hit) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end else if (sample && bit_cnt == 6'd7) begin
                    state_nx = RX_STOP;
                end
            RX_STOP:
                if (idle_hit) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end else if (flag && din_rise) begin
                    cmd_done = 1'b1;
                    state_nx = is_known ? GAP : IGNORE;
                end
            IGNORE:
                if (idle_hit && din_s2)
                    state_nx = IDLE;
            GAP:
                if (tmr == GAP_END) begin
                    tx_start = 1'b1;
                    state_nx = TX;
                end
            TX:
                if (bit_done) begin
                    if (bit_cnt == 6'd1)
                        state_nx = TX_STOP;
                    else
                        tx_start = 1'b1;
                end
            TX_STOP:
                if (tmr == STOP_END) begin
                    tx_end   = 1'b1;
                    state_nx = IDLE;
                end
            default:
                state_nx = IDLE;
        endcase
    end

    // flag: "bit sampled" in RX_BIT, "stop bit fell" in RX_STOP
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            din_s1   <= 1'b1;
            din_s2   <= 1'b1;
            din_q    <= 1'b1;
            tmr      <= '0;
            idle_cnt <= '0;
            flag     <= 1'b0;
            bit_cnt  <= '0;
            rx_sr    <= '0;
            last_cmd <= '0;
            tx_sr    <= '0;
            buttons  <= '0;
            rx_err   <= 1'b0;
            poll_cnt <= '0;
            Dout     <= 1'b1;
        end else begin
            din_s1 <= Din;
            din_s2 <= din_s1;
            din_q  <= din_s2;
            if (state_nx != state || (state == RX_BIT && din_fall))
                tmr <= '0;
            else
                tmr <= tmr + 1'b1;
            if (din_fall || din_rise)
                idle_cnt <= '0;
            else if (!idle_hit)
                idle_cnt <= idle_cnt + 1'b1;
            if (state == IDLE) begin
                flag    <= 1'b0;
                bit_cnt <= '0;
            end
            if (din_fall && (state == RX_BIT))
                flag <= 1'b0;
            if (din_fall && (state == RX_STOP))
                flag <= 1'b1;
            if (sample) begin
                rx_sr   <= {rx_sr[6:0], din_s2};
                bit_cnt <= bit_cnt + 1'b1;
                flag    <= (bit_cnt != 6'd7);
            end
            if (cmd_done) begin
                last_cmd <= rx_sr;
                bit_cnt  <= (rx_sr == CMD_POLL) ? 6'd32 : 6'd24;
                tx_sr    <= (rx_sr == CMD_POLL) ? buttons : {DEV_ID, 8'h00};
            end
            if (tx_start)
                tx_sr <= {tx_sr[30:0], 1'b0};
            if (state == TX && bit_done)
                bit_cnt <= bit_cnt - 1'b1;
            if (abort)
                rx_err <= 1'b1;
            if (poll_done)
                poll_cnt <= poll_cnt + 1'b1;
            Dout <= ~((state == TX && bit_low) || state == TX_STOP);
            if (apb_wr && PADDR[3:2] == REG_BUTTONS)
                buttons <= PWDATA;
            if (ctrl_wr && PWDATA[0]) begin
                rx_err   <= 1'b0;
                poll_cnt <= '0;
            end
        end
    end

`ifdef N64_RESP_IRQ_EN
    logic irq_pend;

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            IRQ      <= 1'b0;
            irq_pend <= 1'b0;
        end else begin
            IRQ <= poll_done;
            if (poll_done)
                irq_pend <= 1'b1;
            if (ctrl_wr && PWDATA[1])
                irq_pend <= 1'b0;
        end
    end

    assign st_irq = irq_pend;
`else
    assign st_irq = 1'b0;
`endif

    always_comb begin
        PRDATA = '0;
        case (PADDR[3:2])
            REG_BUTTONS: PRDATA = buttons;
            REG_STATUS:  PRDATA = {16'h0, last_cmd, 5'h0, st_irq, rx_err, busy};
            REG_POLLCNT: PRDATA = {16'h0, poll_cnt};
            default:     PRDATA = '0;
        endcase
    end

endmodule

// File: tb/tb_n64_controller_responder.sv
// Bench for n64_controller_responder: host model on a wired-AND line,
// Dout frame decoder with an expected-frame scoreboard.
module tb_n64_controller_responder;
    import n64_pkg::*;

    localparam int CPU = 25;

    logic        PCLK = 1'b0;
    logic        PRESERN = 1'b1;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR, Din, Dout;
    logic        host_line = 1'b1;
`ifdef N64_RESP_IRQ_EN
    logic        IRQ;
`endif

    assign Din = Dout & host_line;
    always #5 PCLK = ~PCLK;

    n64_controller_responder #(.CLKS_PER_US(CPU)) dut (
        .PCLK    (PCLK),
        .PRESERN (PRESERN),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .PRDATA  (PRDATA),
`ifdef N64_RESP_IRQ_EN
        .IRQ     (IRQ),
`endif
        .Din     (Din),
        .Dout    (Dout)
    );

    typedef struct {
        logic [5:0]  len;
        logic [31:0] data;
    } frame_t;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] btn;
        logic        resp;
        logic [5:0]  len;
        logic [31:0] data;
    } vec_t;

    frame_t      exp_q[$];
    frame_t      e;
    vec_t        v[5];
    int          n_checks = 0, n_fail = 0;
    int          cyc = 0, frames = 0, dout_falls = 0, irq_hi = 0;
    int          first_fall_cyc = 0, rel_cyc = 0;
    int          mon_low = 0, mon_len = 0;
    int          w_one = 0, w_zero = 0, w_stop = 0;
    logic [31:0] mon_data = '0;
    logic        in_frame = 1'b0;
    logic [31:0] rd;
    int          f0, n0, pollcnt_exp, polls_done;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic apb_write(input logic [1:0] r, input logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0;
        PADDR = {28'h0, r, 2'b00}; PWDATA = d;
        clks(1);
        PENABLE = 1'b1;
        clks(1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [1:0] r, output logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0;
        PADDR = {28'h0, r, 2'b00};
        clks(1);
        PENABLE = 1'b1;
        #1 d = PRDATA;
        clks(1);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic host_bit(input logic b);
        host_line = 1'b0;
        clks(b ? CPU : 3 * CPU);
        host_line = 1'b1;
        clks(b ? 3 * CPU : CPU);
    endtask

    task automatic host_cmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--)
            host_bit(c[i]);
        host_line = 1'b0;
        clks(CPU);
        host_line = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic wait_frame(input int fstart);
        int t = 0;
        while (frames == fstart && t < 200 * CPU) begin
            @(posedge PCLK);
            t++;
        end
        #1;
        check("frame_seen", 32'(frames - fstart), 32'd1);
    endtask

    // Dout decoder: low width 1us -> '1', 3us -> '0', 2us -> stop
    always @(negedge PCLK) begin
        cyc++;
`ifdef N64_RESP_IRQ_EN
        if (IRQ === 1'b1)
            irq_hi++;
`endif
        if (!PRESERN) begin
            mon_low = 0; mon_len = 0; mon_data = '0; in_frame = 1'b0;
        end else if (Dout === 1'b0) begin
            if (mon_low == 0) begin
                dout_falls++;
                if (!in_frame) begin
                    in_frame = 1'b1;
                    first_fall_cyc = cyc;
                end
            end
            mon_low++;
        end else if (mon_low != 0) begin
            if (mon_low * 2 < 3 * CPU) begin
                w_one = mon_low;
                mon_data = {mon_data[30:0], 1'b1};
                mon_len++;
            end else if (mon_low * 2 >= 5 * CPU) begin
                w_zero = mon_low;
                mon_data = {mon_data[30:0], 1'b0};
                mon_len++;
            end else begin
                w_stop = mon_low;
                frames++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame: unexpected len %0d data %h",
                             mon_len, mon_data);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_len", 32'(mon_len), 32'(e.len));
                    check("frame_data", mon_data, e.data);
                end
                mon_len = 0; mon_data = '0; in_frame = 1'b0;
            end
            mon_low = 0;
        end
    end

    initial begin
        v[0] = '{CMD_POLL,   32'h8000_1234, 1'b1, 6'd32, 32'h8000_1234};
        v[1] = '{CMD_STATUS, 32'h0,         1'b1, 6'd24, 32'h0005_0002};
        v[2] = '{CMD_RESET,  32'h0,         1'b1, 6'd24, 32'h0005_0002};
        v[3] = '{8'h41,      32'h0,         1'b0, 6'd0,  32'h0};
        v[4] = '{CMD_POLL,   32'hA5A5_5A5A, 1'b1, 6'd32, 32'hA5A5_5A5A};
        pollcnt_exp = 0;
        polls_done = 0;

        #2 PRESERN = 1'b0;
        clks(3);
        check("rst_dout", 32'(Dout), 32'd1);
        apb_read(REG_BUTTONS, rd); check("rst_buttons", rd, 32'h0);
        apb_read(REG_STATUS, rd);  check("rst_status", rd, 32'h0);
        apb_read(REG_POLLCNT, rd); check("rst_pollcnt", rd, 32'h0);
        apb_read(REG_CTRL, rd);    check("rst_ctrl", rd, 32'h0);
        check("pready", 32'(PREADY), 32'd1);
        check("pslverr", 32'(PSLVERR), 32'd0);
        PRESERN = 1'b1;
        clks(5);

        for (int i = 0; i < 5; i++) begin
            apb_write(REG_BUTTONS, v[i].btn);
            if (v[i].resp)
                exp_q.push_back('{v[i].len, v[i].data});
            f0 = frames;
            n0 = dout_falls;
            host_cmd(v[i].cmd);
            if (v[i].resp) begin
                wait_frame(f0);
            end else begin
                clks(4 * CPU);
                check("no_resp_falls", 32'(dout_falls), 32'(n0));
            end
            if (v[i].cmd == CMD_POLL) begin
                pollcnt_exp++;
                polls_done++;
            end
            if (i == 0) begin
                check("gap_ok", 32'(first_fall_cyc - rel_cyc >= 2 * CPU &&
                      first_fall_cyc - rel_cyc <= 2 * CPU + 10), 32'd1);
                check("width_one", 32'(w_one), 32'(CPU));
                check("width_zero", 32'(w_zero), 32'(3 * CPU));
                check("width_stop", 32'(w_stop), 32'(2 * CPU));
            end
            clks(20 * CPU);
            apb_read(REG_STATUS, rd);
            check("status_cmd", 32'(rd[15:8]), 32'(v[i].cmd));
            check("status_busy", 32'(rd[0]), 32'd0);
            apb_read(REG_POLLCNT, rd);
            check("pollcnt", rd, 32'(pollcnt_exp));
        end

        // button write during a reply only affects the next poll
        apb_write(REG_BUTTONS, 32'h0);
        exp_q.push_back('{6'd32, 32'h0});
        f0 = frames;
        host_cmd(CMD_POLL);
        clks(30 * CPU);
        apb_write(REG_BUTTONS, 32'hFFFF_FFFF);
        wait_frame(f0);
        pollcnt_exp++; polls_done++;
        clks(8 * CPU);
        exp_q.push_back('{6'd32, 32'hFFFF_FFFF});
        f0 = frames;
        host_cmd(CMD_POLL);
        wait_frame(f0);
        pollcnt_exp++; polls_done++;
        clks(8 * CPU);
        apb_read(REG_POLLCNT, rd);
        check("pollcnt_mid", rd, 32'(pollcnt_exp));

        // truncated command: 5 bits then idle
        n0 = dout_falls;
        host_bit(1'b1); host_bit(1'b0); host_bit(1'b1);
        host_bit(1'b1); host_bit(1'b0);
        clks(20 * CPU);
        check("trunc_no_resp", 32'(dout_falls), 32'(n0));
        apb_read(REG_STATUS, rd);
        check("trunc_err_busy", 32'(rd[1:0]), 32'd2);
        apb_write(REG_CTRL, 32'h1);
        pollcnt_exp = 0;
        apb_read(REG_STATUS, rd);
        check("clr_err", 32'(rd[1:0]), 32'd0);
        apb_read(REG_POLLCNT, rd);
        check("clr_pollcnt", rd, 32'(pollcnt_exp));

        // line stuck low
        host_line = 1'b0;
        clks(20 * CPU);
        host_line = 1'b1;
        clks(5 * CPU);
        apb_read(REG_STATUS, rd);
        check("stuck_err_busy", 32'(rd[1:0]), 32'd2);
        apb_write(REG_CTRL, 32'h1);

        // reset in the middle of a reply
        apb_write(REG_BUTTONS, 32'hFFFF_FFFF);
        exp_q.push_back('{6'd32, 32'hFFFF_FFFF});
        host_cmd(CMD_POLL);
        clks(30 * CPU);
        PRESERN = 1'b0;
        #1;
        check("midtx_rst_dout", 32'(Dout), 32'd1);
        apb_read(REG_BUTTONS, rd); check("midtx_rst_btn", rd, 32'h0);
        apb_read(REG_STATUS, rd);  check("midtx_rst_status", rd, 32'h0);
        exp_q.delete();
        pollcnt_exp = 0;
        PRESERN = 1'b1;
        clks(10);
        exp_q.push_back('{6'd32, 32'h0});
        f0 = frames;
        host_cmd(CMD_POLL);
        wait_frame(f0);
        pollcnt_exp++; polls_done++;
        clks(8 * CPU);
        apb_read(REG_POLLCNT, rd);
        check("post_rst_pollcnt", rd, 32'(pollcnt_exp));
        check("exp_drained", 32'(exp_q.size()), 32'd0);
`ifdef N64_RESP_IRQ_EN
        check("irq_pulses", 32'(irq_hi), 32'(polls_done));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
